// File: rtl/logic_pkg.sv
// Shared JK command encodings and the helper that picks a {J,K} pair
// for one bit from its current and next value.
`default_nettype none

package logic_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // Only hold or toggle is ever issued, so the cell never depends on J/K asymmetry.
  function automatic logic [1:0] jk_from_bits(input logic cur, input logic nxt);
    return (cur != nxt) ? JK_TOGGLE : JK_HOLD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jk_cell.sv
// One-bit JK storage cell with asynchronous active-low clear.
`default_nettype none

module jk_cell
  import logic_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qn
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        JK_HOLD:  q <= q;
        JK_RESET: q <= 1'b0;
        JK_SET:   q <= 1'b1;
        default:  q <= ~q;
      endcase
    end
  end

  assign qn = ~q;

endmodule

`default_nettype wire

// File: rtl/jk_sync_counter.sv
// Modulo-MODULUS up/down counter built from WIDTH JK cells, with load clamp,
// combinational terminal count and a wrap pulse delayed by one edge.
`default_nettype none

module jk_sync_counter
  import logic_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             wrap_evt;
  logic             wrap_pend;

  always_comb begin
    nxt      = q;
    wrap_evt = 1'b0;
    if (load) begin
      nxt = (din > MAX_VAL) ? MAX_VAL : din;
    end else if (en) begin
      if (q > MAX_VAL) begin
        // Recovery from an illegal state: always back to zero.
        nxt = '0;
      end else if (up) begin
        if (q == MAX_VAL) begin
          nxt      = '0;
          wrap_evt = 1'b1;
        end else begin
          nxt = q + WIDTH'(1);
        end
      end else begin
        if (q == '0) begin
          nxt      = MAX_VAL;
          wrap_evt = 1'b1;
        end else begin
          nxt = q - WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    j = '0;
    k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {j[i], k[i]} = jk_from_bits(q[i], nxt[i]);
    end
  end

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      jk_cell u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .j     (j[i]),
        .k     (k[i]),
        .q     (q[i]),
        .qn    (qn[i])
      );
    end
  endgenerate

  assign tc = en & ~load & ((up & (q == MAX_VAL)) | (~up & (q == '0)));

  // Two stages so the pulse appears on the edge after the wrap and a reset
  // in between cancels it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_pend <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      wrap_pend <= wrap_evt;
      wrap      <= wrap_pend;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jk_sync_counter.sv
// Self-checking bench: vector table, directed corner sequences, random run
// against an arithmetic model, and a two-stage cascade.
`default_nettype none

module tb_jk_sync_counter;

  localparam int M = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0, up = 1'b1, load = 1'b0;
  logic [3:0] din = 4'd0;
  logic [3:0] q, qn, tq, tqn;
  logic       tc, wrap, ttc, twrap;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int mq = 0, mt = 0, mwrap = 0, mpend = 0;
  int watch = 0, wrap_seen = 0;

  always #5 clk = ~clk;

  jk_sync_counter #(.WIDTH(4), .MODULUS(M)) u_units (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .din(din),
    .q(q), .qn(qn), .tc(tc), .wrap(wrap)
  );

  jk_sync_counter #(.WIDTH(4), .MODULUS(M)) u_tens (
    .clk(clk), .rst_n(rst_n), .en(tc), .up(1'b1), .load(1'b0), .din(4'd0),
    .q(tq), .qn(tqn), .tc(ttc), .wrap(twrap)
  );

  always @(posedge wrap) if (watch != 0) wrap_seen = 1;

  typedef struct {
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] din;
    int         q;
    int         tc;
    int         wrap;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drives nothing; applies one edge with the current inputs and checks
  // tc before the edge and q/qn/wrap/tens after it.
  task automatic step(input string nm);
    int exp_tc, nq, evt;
    exp_tc = (en && !load && (up ? (mq == M - 1) : (mq == 0))) ? 1 : 0;
    #1;
    check({nm, " tc"}, int'(tc), exp_tc);
    @(posedge clk);
    evt = 0;
    if (load) begin
      nq = (int'(din) >= M) ? M - 1 : int'(din);
    end else if (en) begin
      nq = up ? mq + 1 : mq - 1;
      if (nq < 0 || nq >= M) evt = 1;
      nq = (nq + M) % M;
    end else begin
      nq = mq;
    end
    if (evt != 0) mt = (mt + 1) % M;
    mq    = nq;
    mwrap = mpend;
    mpend = evt;
    #1;
    check({nm, " q"},    int'(q),    mq);
    check({nm, " qn"},   int'(qn),   15 - mq);
    check({nm, " wrap"}, int'(wrap), mwrap);
    check({nm, " tens"}, int'(tq),   mt);
  endtask

  task automatic drive(input logic e, input logic u, input logic l, input logic [3:0] d);
    en = e; up = u; load = l; din = d;
  endtask

  // Async reset asserted mid-cycle, checked immediately, released mid-cycle.
  task automatic do_reset(input string nm);
    #2;
    rst_n = 1'b0;
    #1;
    check({nm, " rst q"},    int'(q),    0);
    check({nm, " rst qn"},   int'(qn),   15);
    check({nm, " rst wrap"}, int'(wrap), 0);
    check({nm, " rst tens"}, int'(tq),   0);
    drive(1'b1, 1'b1, 1'b1, 4'd5);
    @(posedge clk);
    #1;
    check({nm, " rst held q"}, int'(q), 0);
    @(negedge clk);
    rst_n = 1'b1;
    mq = 0; mt = 0; mwrap = 0; mpend = 0;
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    step({nm, " post-rst"});
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 4'd3,  3, 0, 0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 4'd0,  4, 0, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 4'd6,  6, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 4'd13, 9, 0, 0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 4'd0,  0, 1, 0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 4'd0,  0, 0, 1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 4'd0,  9, 1, 0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 4'd0,  8, 0, 1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 4'd0,  8, 0, 0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 4'd15, 9, 0, 0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 4'd0,  0, 1, 0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 4'd0,  9, 1, 1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 4'd0,  9, 0, 1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 4'd0,  9, 0, 0};

    #1 rst_n = 1'b0;
    #1;
    check("init q",    int'(q),    0);
    check("init qn",   int'(qn),   15);
    check("init wrap", int'(wrap), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Vector table from q=0
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].en, tbl[i].up, tbl[i].load, tbl[i].din);
      #1;
      check($sformatf("tbl%0d tc", i), int'(tc), tbl[i].tc);
      step($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d vq", i),    int'(q),    tbl[i].q);
      check($sformatf("tbl%0d vwrap", i), int'(wrap), tbl[i].wrap);
    end

    // Reset mid-cycle with q=7, then hold for three edges
    drive(1'b0, 1'b1, 1'b1, 4'd7);
    step("ld7");
    do_reset("r7");
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) step("hold0");

    // Full up run through a wrap and the following pulse
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 12; i++) step($sformatf("up%0d", i));

    // Down wrap from 0
    do_reset("rd");
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) step($sformatf("dn%0d", i));

    // Wrap, then reset before the pulse can appear, then count down
    drive(1'b0, 1'b1, 1'b1, 4'd9);
    step("mw ld9");
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    step("mw wrap");
    watch = 1;
    do_reset("mw");
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    step("mw idle");
    watch = 0;
    check("mw wrap_seen", wrap_seen, 0);
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    step("mw down");
    check("mw q9", int'(q), 9);

    // Cascade: 25 counts from 00
    do_reset("cas");
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 25; i++) step($sformatf("cas%0d", i));
    check("cas tens", int'(tq), 2);
    check("cas units", int'(q), 5);

    // Random traffic with occasional mid-cycle resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset($sformatf("rnd%0d", i));
      end else begin
        drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
              ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
        step($sformatf("rnd%0d", i));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
